// File: rtl/piso_serializer.sv
// Framing PISO transmitter: a one-word holding register feeds a start / WIDTH data (LSB first) / stop
// serial frame, advanced only on shift_en ticks.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_data,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_sout_data;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;

    // Ready drops with reset so no word can be accepted on a reset edge.
    assign din_ready = !r_hold_full && !reset;
    assign w_accept  = din_valid && din_ready;

    assign sout      = r_sout;
    assign sout_data = r_sout_data;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: hold and shreg are reset too, so an aborted frame leaves nothing to re-send.
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_sout      <= 1'b1;
            r_sout_data <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Accept needs an empty holder and transfer needs a full one, so they never collide.
            if (w_accept) begin
                r_hold      <= din;
                r_hold_full <= 1'b1;
            end

            if (shift_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_hold_full) begin
                            r_shreg     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_sout      <= 1'b0;
                            r_state     <= S_START;
                            r_busy      <= 1'b1;
                        end else begin
                            r_sout <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_sout      <= r_shreg[0];
                        r_shreg     <= r_shreg >> 1;
                        r_cnt       <= '0;
                        r_sout_data <= 1'b1;
                        r_state     <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_cnt == LAST_CNT) begin
                            r_sout      <= 1'b1;
                            r_sout_data <= 1'b0;
                            r_state     <= S_STOP;
                        end else begin
                            r_sout  <= r_shreg[0];
                            r_shreg <= r_shreg >> 1;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                    S_STOP: begin
                        r_done <= 1'b1;
                        // A queued word starts immediately: no idle bit between frames.
                        if (r_hold_full) begin
                            r_shreg     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_sout      <= 1'b0;
                            r_state     <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
